// File: rtl/sonar_pkg.sv
// Shared sonar front-end types and default sizing (FIR, decimator, downstream stages).
package sonar_pkg;
  localparam int DATA_W     = 32;
  localparam int CH_BITS    = 2;
  localparam int NUM_CH     = 1 << CH_BITS;
  localparam int LOG2_DECIM = 3;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [CH_BITS-1:0]       chan_t;
endpackage

// File: rtl/decim_acc_bank.sv
// Per-channel boxcar accumulators and sample counters.
// The selected channel's running sum including the incoming sample is exposed
// combinationally together with a dump flag, so the top can load its output
// register on the same edge the block completes.
module decim_acc_bank #(
  parameter int DATA_W     = sonar_pkg::DATA_W,
  parameter int CH_BITS    = sonar_pkg::CH_BITS,
  parameter int LOG2_DECIM = sonar_pkg::LOG2_DECIM
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               wr_en_i,
  input  logic [CH_BITS-1:0] ch_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               dump_o,
  output logic [DATA_W-1:0]  avg_o
);
  localparam int NUM_CH = 1 << CH_BITS;
  // LOG2_DECIM guard bits make the block sum overflow-free.
  localparam int ACC_W  = DATA_W + LOG2_DECIM;
  localparam int CNT_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);

  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic        [CNT_W-1:0] cnt_q [NUM_CH];
  logic        [CNT_W-1:0] cnt_d [NUM_CH];

  logic signed [ACC_W-1:0] cur_acc;
  logic signed [ACC_W-1:0] sum;
  logic        [CNT_W-1:0] cur_cnt;

  // Effective state of the addressed channel: a same-cycle clear makes the
  // incoming sample the first of a fresh block.
  always_comb begin
    cur_acc = clear_i ? '0 : acc_q[ch_i];
    cur_cnt = clear_i ? '0 : cnt_q[ch_i];
    sum     = cur_acc + ACC_W'($signed(data_i));
    dump_o  = (cur_cnt == CNT_LAST);
    // Dropping the low bits of a two's-complement sum is a floor divide.
    avg_o   = sum[ACC_W-1:LOG2_DECIM];
  end

  // Next state: clear flushes every channel, then the accepted sample either
  // accumulates or dumps on its own channel only.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = clear_i ? '0 : acc_q[c];
      cnt_d[c] = clear_i ? '0 : cnt_q[c];
    end
    if (wr_en_i) begin
      if (dump_o) begin
        acc_d[ch_i] = '0;
        cnt_d[ch_i] = '0;
      end else begin
        acc_d[ch_i] = sum;
        cnt_d[ch_i] = cur_cnt + CNT_W'(1);
      end
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end
endmodule

// File: rtl/channel_decimator.sv
// Per-channel average-and-decimate stage on the FIR's interleaved AXI-Stream.
// One output register; input ready is a pure function of the output state.
module channel_decimator #(
  parameter int DATA_W     = sonar_pkg::DATA_W,
  parameter int CH_BITS    = sonar_pkg::CH_BITS,
  parameter int LOG2_DECIM = sonar_pkg::LOG2_DECIM
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_arstn,
  input  logic               clear,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [CH_BITS-1:0] s_axis_tuser,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [CH_BITS-1:0] m_axis_tuser
);
  logic               accept;
  logic               dump;
  logic               load;
  logic [DATA_W-1:0]  avg;

  logic               m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]  m_tdata_q,  m_tdata_d;
  logic [CH_BITS-1:0] m_tuser_q,  m_tuser_d;

  decim_acc_bank #(
    .DATA_W     (DATA_W),
    .CH_BITS    (CH_BITS),
    .LOG2_DECIM (LOG2_DECIM)
  ) u_bank (
    .clk_i   (s_axis_aclk),
    .rst_ni  (s_axis_arstn),
    .clear_i (clear),
    .wr_en_i (accept),
    .ch_i    (s_axis_tuser),
    .data_i  (s_axis_tdata),
    .dump_o  (dump),
    .avg_o   (avg)
  );

  // Handshake and output-register next state; a dump on the same edge as an
  // output handshake reloads the register for full throughput.
  always_comb begin
    s_axis_tready = !m_tvalid_q || m_axis_tready;
    accept        = s_axis_tvalid && s_axis_tready;
    load          = accept && dump;
    m_tvalid_d    = m_tvalid_q && !m_axis_tready;
    m_tdata_d     = m_tdata_q;
    m_tuser_d     = m_tuser_q;
    if (load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = avg;
      m_tuser_d  = s_axis_tuser;
    end
  end

  // Output register; clear deliberately leaves a pending result in place.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
endmodule
